// File: rtl/otp_ctrl_macro_arb.sv
// Round-robin arbiter placing several OTP agents (DAI, LCI, ...) onto the single OTP macro port.
// One transaction is in flight at a time; escalation and protocol errors park the FSM in ErrorSt.
module otp_ctrl_macro_arb #(
    parameter int NumAgents = 2,
    parameter int AddrW     = 10,
    parameter int DataW     = 64,
    parameter int SizeW     = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [3:0]                          escalate_en_i,
    input  logic [NumAgents-1:0]                agt_req_i,
    input  logic [NumAgents-1:0][2:0]           agt_cmd_i,
    input  logic [NumAgents-1:0][SizeW-1:0]     agt_size_i,
    input  logic [NumAgents-1:0][DataW-1:0]     agt_wdata_i,
    input  logic [NumAgents-1:0][AddrW-1:0]     agt_addr_i,
    output logic [NumAgents-1:0]                agt_gnt_o,
    output logic [NumAgents-1:0]                agt_rvalid_o,
    output logic [DataW-1:0]                    agt_rdata_o,
    output logic [2:0]                          agt_err_o,
    output logic                                otp_req_o,
    output logic [2:0]                          otp_cmd_o,
    output logic [SizeW-1:0]                    otp_size_o,
    output logic [DataW-1:0]                    otp_wdata_o,
    output logic [AddrW-1:0]                    otp_addr_o,
    input  logic                                otp_gnt_i,
    input  logic                                otp_rvalid_i,
    input  logic [DataW-1:0]                    otp_rdata_i,
    input  logic [2:0]                          otp_err_i,
    output logic                                idle_o,
    output logic                                fsm_err_o
);

    localparam int IdxW = (NumAgents > 1) ? $clog2(NumAgents) : 1;
    localparam logic [3:0] LcTxOff = 4'b1010;

    // Pairwise Hamming distance >= 3 between all legal encodings.
    typedef enum logic [4:0] {
        IdleSt  = 5'b10110,
        WaitSt  = 5'b01101,
        ErrorSt = 5'b11011
    } state_e;

    logic [4:0]      state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] prio_q, prio_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;

    logic            esc;
    logic            sel_vld;
    logic [IdxW-1:0] sel_idx;

    assign esc = (escalate_en_i != LcTxOff);

    // A locked agent keeps the port until granted; once it drops, the scan reruns immediately.
    always_comb begin : p_arb
        logic [IdxW-1:0] cand;
        cand    = '0;
        sel_vld = 1'b0;
        sel_idx = '0;
        if (lock_q && agt_req_i[lock_idx_q]) begin
            sel_vld = 1'b1;
            sel_idx = lock_idx_q;
        end else begin
            for (int k = 0; k < NumAgents; k++) begin
                cand = IdxW'((int'(prio_q) + k) % NumAgents);
                if (!sel_vld && agt_req_i[cand]) begin
                    sel_vld = 1'b1;
                    sel_idx = cand;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        prio_d       = prio_q;
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        otp_req_o    = 1'b0;
        agt_gnt_o    = '0;
        agt_rvalid_o = '0;
        agt_rdata_o  = '0;
        agt_err_o    = '0;
        fsm_err_o    = 1'b0;

        case (state_q)
            IdleSt: begin
                otp_req_o = sel_vld && !esc;
                if (otp_rvalid_i) begin
                    fsm_err_o = 1'b1;
                    state_d   = ErrorSt;
                end else if (otp_req_o && otp_gnt_i) begin
                    agt_gnt_o[sel_idx] = 1'b1;
                    owner_d = sel_idx;
                    prio_d  = (int'(sel_idx) == NumAgents - 1) ? '0 : sel_idx + 1'b1;
                    lock_d  = 1'b0;
                    state_d = WaitSt;
                end else if (otp_req_o) begin
                    lock_d     = 1'b1;
                    lock_idx_d = sel_idx;
                end else begin
                    lock_d = 1'b0;
                end
            end
            WaitSt: begin
                if (otp_rvalid_i) begin
                    agt_rvalid_o[owner_q] = 1'b1;
                    agt_rdata_o = otp_rdata_i;
                    agt_err_o   = otp_err_i;
                    state_d     = IdleSt;
                end
            end
            ErrorSt: ;
            default: begin
                fsm_err_o = 1'b1;
                state_d   = ErrorSt;
            end
        endcase

        if (esc) begin
            state_d      = ErrorSt;
            fsm_err_o    = 1'b1;
            agt_gnt_o    = '0;
            agt_rvalid_o = '0;
            agt_rdata_o  = '0;
            agt_err_o    = '0;
        end
    end

    assign otp_cmd_o   = otp_req_o ? agt_cmd_i[sel_idx]   : '0;
    assign otp_size_o  = otp_req_o ? agt_size_i[sel_idx]  : '0;
    assign otp_wdata_o = otp_req_o ? agt_wdata_i[sel_idx] : '0;
    assign otp_addr_o  = otp_req_o ? agt_addr_i[sel_idx]  : '0;
    assign idle_o      = (state_q == IdleSt) && !(|agt_req_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IdleSt;
            owner_q    <= '0;
            prio_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_otp_ctrl_macro_arb.sv
// Bench for otp_ctrl_macro_arb: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration rules.
module tb_otp_ctrl_macro_arb;
    localparam int N = 2;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int SW = 2;
    localparam logic [3:0] OFF = 4'b1010;
    localparam logic [3:0] ON  = 4'b0101;

    logic clk = 1'b0;
    logic rst_ni;
    logic [3:0] escalate_en;
    logic [N-1:0] agt_req;
    logic [N-1:0][2:0] agt_cmd;
    logic [N-1:0][SW-1:0] agt_size;
    logic [N-1:0][DW-1:0] agt_wdata;
    logic [N-1:0][AW-1:0] agt_addr;
    logic [N-1:0] agt_gnt, agt_rvalid;
    logic [DW-1:0] agt_rdata;
    logic [2:0] agt_err;
    logic otp_req;
    logic [2:0] otp_cmd;
    logic [SW-1:0] otp_size;
    logic [DW-1:0] otp_wdata;
    logic [AW-1:0] otp_addr;
    logic otp_gnt, otp_rvalid;
    logic [DW-1:0] otp_rdata;
    logic [2:0] otp_err;
    logic idle, fsm_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    otp_ctrl_macro_arb #(.NumAgents(N), .AddrW(AW), .DataW(DW), .SizeW(SW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .escalate_en_i(escalate_en),
        .agt_req_i(agt_req), .agt_cmd_i(agt_cmd), .agt_size_i(agt_size),
        .agt_wdata_i(agt_wdata), .agt_addr_i(agt_addr),
        .agt_gnt_o(agt_gnt), .agt_rvalid_o(agt_rvalid),
        .agt_rdata_o(agt_rdata), .agt_err_o(agt_err),
        .otp_req_o(otp_req), .otp_cmd_o(otp_cmd), .otp_size_o(otp_size),
        .otp_wdata_o(otp_wdata), .otp_addr_o(otp_addr),
        .otp_gnt_i(otp_gnt), .otp_rvalid_i(otp_rvalid),
        .otp_rdata_i(otp_rdata), .otp_err_i(otp_err),
        .idle_o(idle), .fsm_err_o(fsm_err)
    );

    task automatic clear_inputs();
        escalate_en = OFF;
        agt_req = '0; agt_cmd = '0; agt_size = '0; agt_wdata = '0; agt_addr = '0;
        otp_gnt = 1'b0; otp_rvalid = 1'b0; otp_rdata = '0; otp_err = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b exp=1", idle); end
        n_cmp++; if ({otp_req, agt_gnt, agt_rvalid, fsm_err} !== '0) begin n_err++;
            $display("FAIL reset_outs got=%b exp=0", {otp_req, agt_gnt, agt_rvalid, fsm_err}); end
        n_cmp++; if ({agt_rdata, agt_err, otp_addr, otp_wdata} !== '0) begin n_err++;
            $display("FAIL reset_data got nonzero exp=0"); end
        rst_ni = 1'b1;
    endtask

    // Both agents request with gnt held low: agent 0 keeps the port.
    task automatic test_hold();
        do_reset();
        agt_req = 2'b11; agt_addr[0] = 10'h011; agt_addr[1] = 10'h022;
        agt_cmd[0] = 3'd2; agt_cmd[1] = 3'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (otp_req !== 1'b1 || otp_addr !== 10'h011 || otp_cmd !== 3'd2) begin n_err++;
                $display("FAIL hold_addr cyc=%0d got req=%b addr=%h exp req=1 addr=011", c, otp_req, otp_addr); end
            @(negedge clk);
        end
        otp_gnt = 1'b1; #1;
        n_cmp++; if (agt_gnt !== 2'b01) begin n_err++; $display("FAIL hold_gnt got=%b exp=01", agt_gnt); end
        @(negedge clk); otp_gnt = 1'b0; agt_req = '0; #1;
        n_cmp++; if (otp_req !== 1'b0 || idle !== 1'b0) begin n_err++;
            $display("FAIL hold_wait got req=%b idle=%b exp 0/0", otp_req, idle); end
        @(negedge clk); otp_rvalid = 1'b1; otp_rdata = 64'h55; #1;
        n_cmp++; if (agt_rvalid !== 2'b01 || agt_rdata !== 64'h55) begin n_err++;
            $display("FAIL hold_rvalid got=%b data=%h exp=01 data=55", agt_rvalid, agt_rdata); end
        @(negedge clk); otp_rvalid = 1'b0;
    endtask

    // Lock survives a higher-priority newcomer, and is released when the holder drops.
    task automatic test_lock();
        do_reset();
        agt_req = 2'b10; agt_addr[0] = 10'h100; agt_addr[1] = 10'h200; #1;
        n_cmp++; if (otp_addr !== 10'h200) begin n_err++; $display("FAIL lock_first got=%h exp=200", otp_addr); end
        @(negedge clk); agt_req = 2'b11; #1;
        n_cmp++; if (otp_addr !== 10'h200) begin n_err++; $display("FAIL lock_keep got=%h exp=200", otp_addr); end
        @(negedge clk); agt_req = 2'b01; #1;
        n_cmp++; if (otp_req !== 1'b1 || otp_addr !== 10'h100) begin n_err++;
            $display("FAIL lock_release got req=%b addr=%h exp req=1 addr=100", otp_req, otp_addr); end
        otp_gnt = 1'b1; #1;
        n_cmp++; if (agt_gnt !== 2'b01) begin n_err++; $display("FAIL lock_gnt got=%b exp=01", agt_gnt); end
        @(negedge clk); otp_gnt = 1'b0; agt_req = '0;
        @(negedge clk); otp_rvalid = 1'b1;
        @(negedge clk); otp_rvalid = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        agt_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp = N'(1 << (t % 2));
            otp_gnt = 1'b1; #1;
            n_cmp++; if (agt_gnt !== exp) begin n_err++;
                $display("FAIL rr_gnt t=%0d got=%b exp=%b", t, agt_gnt, exp); end
            @(negedge clk); otp_gnt = 1'b0; #1;
            n_cmp++; if (otp_req !== 1'b0) begin n_err++;
                $display("FAIL rr_wait t=%0d got req=%b exp=0", t, otp_req); end
            @(negedge clk); otp_rvalid = 1'b1; #1;
            n_cmp++; if (agt_rvalid !== exp) begin n_err++;
                $display("FAIL rr_rvalid t=%0d got=%b exp=%b", t, agt_rvalid, exp); end
            @(negedge clk); otp_rvalid = 1'b0;
        end
        agt_req = '0;
    endtask

    task automatic test_read_data();
        do_reset();
        agt_req = 2'b10; agt_addr[1] = 10'h02A; agt_cmd[1] = 3'd1; agt_size[1] = 2'd3;
        otp_gnt = 1'b1; #1;
        n_cmp++; if (otp_addr !== 10'h02A || otp_cmd !== 3'd1 || otp_size !== 2'd3 || agt_gnt !== 2'b10) begin
            n_err++; $display("FAIL rd_req got addr=%h cmd=%0d gnt=%b exp 02a/1/10", otp_addr, otp_cmd, agt_gnt); end
        @(negedge clk); otp_gnt = 1'b0; agt_req = '0; otp_rdata = 64'h1234; otp_err = 3'd5; #1;
        n_cmp++; if (agt_rdata !== '0 || agt_err !== '0) begin n_err++;
            $display("FAIL rd_quiet got data=%h err=%0d exp 0/0", agt_rdata, agt_err); end
        @(negedge clk); otp_rvalid = 1'b1; otp_rdata = 64'hDEADBEEF; otp_err = 3'd1; #1;
        n_cmp++; if (agt_rvalid !== 2'b10 || agt_rdata !== 64'hDEADBEEF || agt_err !== 3'd1) begin n_err++;
            $display("FAIL rd_resp got rv=%b data=%h err=%0d exp 10/deadbeef/1", agt_rvalid, agt_rdata, agt_err); end
        @(negedge clk); otp_rvalid = 1'b0; otp_rdata = '0; otp_err = '0;
    endtask

    task automatic test_unexpected_rvalid();
        do_reset();
        otp_rvalid = 1'b1; #1;
        n_cmp++; if (fsm_err !== 1'b1 || agt_rvalid !== '0) begin n_err++;
            $display("FAIL unexp_err got err=%b rv=%b exp 1/00", fsm_err, agt_rvalid); end
        @(negedge clk); otp_rvalid = 1'b0; #1;
        n_cmp++; if (fsm_err !== 1'b0) begin n_err++; $display("FAIL unexp_pulse got=%b exp=0", fsm_err); end
        agt_req = 2'b11; otp_gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (otp_req !== 1'b0 || agt_gnt !== '0 || idle !== 1'b0) begin n_err++;
                $display("FAIL unexp_dead cyc=%0d got req=%b gnt=%b idle=%b exp 0", c, otp_req, agt_gnt, idle); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_escalate();
        do_reset();
        agt_req = 2'b01; otp_gnt = 1'b1;
        @(negedge clk); agt_req = '0; otp_gnt = 1'b0;
        @(negedge clk); escalate_en = ON; otp_rvalid = 1'b1; otp_rdata = 64'hABCD; #1;
        n_cmp++; if (agt_rvalid !== '0 || fsm_err !== 1'b1 || agt_rdata !== '0) begin n_err++;
            $display("FAIL esc_wait got rv=%b err=%b data=%h exp 00/1/0", agt_rvalid, fsm_err, agt_rdata); end
        @(negedge clk); escalate_en = OFF; otp_rvalid = 1'b0; agt_req = 2'b11; otp_gnt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (otp_req !== 1'b0 || agt_gnt !== '0) begin n_err++;
                $display("FAIL esc_dead cyc=%0d got req=%b gnt=%b exp 0/00", c, otp_req, agt_gnt); end
            @(negedge clk);
        end
        // Any value other than Off escalates, and suppresses a same-cycle grant.
        do_reset();
        agt_req = 2'b01; otp_gnt = 1'b1; escalate_en = 4'h0; #1;
        n_cmp++; if (agt_gnt !== '0 || fsm_err !== 1'b1) begin n_err++;
            $display("FAIL esc_loose got gnt=%b err=%b exp 00/1", agt_gnt, fsm_err); end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_invalid_state();
        do_reset();
        force dut.state_q = 5'b00000;
        #1;
        n_cmp++; if (fsm_err !== 1'b1) begin n_err++; $display("FAIL bad_state_err got=%b exp=1", fsm_err); end
        @(posedge clk); #1;
        release dut.state_q;
        @(posedge clk);
        @(negedge clk);
        agt_req = 2'b01; otp_gnt = 1'b1; #1;
        n_cmp++; if (fsm_err !== 1'b0 || idle !== 1'b0 || otp_req !== 1'b0 || agt_gnt !== '0) begin n_err++;
            $display("FAIL bad_state_park got err=%b idle=%b req=%b gnt=%b exp 0/0/0/00", fsm_err, idle, otp_req, agt_gnt); end
        @(negedge clk); clear_inputs();
    endtask

    // Reference: pending-owner queue of depth one, pointer after last winner, sticky choice.
    task automatic test_random();
        bit busy = 0;
        int ptr = 0, owner = 0, held = -1, sel;
        logic [N-1:0] eg, er;
        logic [DW-1:0] ed;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            agt_req = N'($urandom_range(0, (1 << N) - 1));
            for (int a = 0; a < N; a++) begin
                agt_addr[a] = AW'($urandom); agt_wdata[a] = {$urandom, $urandom};
                agt_cmd[a] = 3'($urandom);
            end
            otp_gnt = ($urandom_range(0, 1) == 1);
            otp_rvalid = busy && ($urandom_range(0, 2) == 0);
            otp_rdata = {$urandom, $urandom}; otp_err = 3'($urandom);
            sel = -1;
            if (!busy) begin
                if (held >= 0 && agt_req[held]) sel = held;
                else for (int k = 0; k < N; k++)
                    if (sel < 0 && agt_req[(ptr + k) % N]) sel = (ptr + k) % N;
            end
            eg = (sel >= 0 && otp_gnt) ? N'(1 << sel) : '0;
            er = otp_rvalid ? N'(1 << owner) : '0;
            ed = otp_rvalid ? otp_rdata : '0;
            #1;
            n_cmp++; if (otp_req !== (sel >= 0) || (sel >= 0 && (otp_addr !== agt_addr[sel] || otp_wdata !== agt_wdata[sel]))) begin
                n_err++; $display("FAIL rnd_req cyc=%0d got req=%b addr=%h exp sel=%0d", cyc, otp_req, otp_addr, sel); end
            n_cmp++; if (agt_gnt !== eg || agt_rvalid !== er || agt_rdata !== ed) begin n_err++;
                $display("FAIL rnd_resp cyc=%0d got gnt=%b rv=%b exp gnt=%b rv=%b", cyc, agt_gnt, agt_rvalid, eg, er); end
            n_cmp++; if (fsm_err !== 1'b0 || idle !== (!busy && agt_req == '0)) begin n_err++;
                $display("FAIL rnd_status cyc=%0d got err=%b idle=%b", cyc, fsm_err, idle); end
            if (busy) begin
                if (otp_rvalid) busy = 0;
            end else if (sel >= 0 && otp_gnt) begin
                busy = 1; owner = sel; ptr = (sel + 1) % N; held = -1;
            end else held = sel;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1'b0;
        @(negedge clk);
        test_reset();
        test_hold();
        test_lock();
        test_round_robin();
        test_read_data();
        test_random();
        test_unexpected_rvalid();
        test_escalate();
        test_invalid_state();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/otp_ctrl_macro_arb.md
OTP_CTRL_MACRO_ARB -- requirements
Module: otp_ctrl_macro_arb

Interface
REQ-001 The block SHALL have parameter NumAgents, default 2, meaning the number of requesting agents (index 0 = DAI, 1 = LCI; legal range 2..4).
REQ-002 The block SHALL have parameter AddrW, default 10, meaning the OTP halfword address width.
REQ-003 The block SHALL have parameter DataW, default 64, meaning the OTP write/read data width.
REQ-004 The block SHALL have parameter SizeW, default 2, meaning the OTP size field width.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the clock.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: the reset, asynchronous, active-low.
REQ-007 The block SHALL have port escalate_en_i, input, 4 bits: an lc_tx_t escalation input; any value other than Off counts as true (loose test).
REQ-008 The block SHALL have the following agent-side ports:
- agt_req_i, input, NumAgents bits: per-agent request.
- agt_cmd_i, input, NumAgents x 3 bits: per-agent command.
- agt_size_i, input, NumAgents x SizeW bits: per-agent size.
- agt_wdata_i, input, NumAgents x DataW bits: per-agent write data.
- agt_addr_i, input, NumAgents x AddrW bits: per-agent address.
- agt_gnt_o, output, NumAgents bits: one-hot grant.
- agt_rvalid_o, output, NumAgents bits: one-hot response valid.
REQ-009 The block SHALL have the following shared response outputs:
- agt_rdata_o, output, DataW bits: read data broadcast to all agents.
- agt_err_o, output, 3 bits: error code broadcast to all agents.
REQ-010 The block SHALL have the following macro-side ports:
- otp_req_o, output, 1 bit.
- otp_cmd_o, output, 3 bits.
- otp_size_o, output, SizeW bits.
- otp_wdata_o, output, DataW bits.
- otp_addr_o, output, AddrW bits.
- otp_gnt_i, input, 1 bit.
- otp_rvalid_i, input, 1 bit.
- otp_rdata_i, input, DataW bits.
- otp_err_i, input, 3 bits.
REQ-011 The block SHALL have the following status outputs:
- idle_o, output, 1 bit: high when in IdleSt with no agent requesting.
- fsm_err_o, output, 1 bit: pulses on an invalid state, an unexpected rvalid, or escalation.

Function
REQ-012 The state machine SHALL have states IdleSt, WaitSt and ErrorSt, sparse-encoded with a minimum Hamming distance of 3; any other state value SHALL go to ErrorSt and pulse fsm_err_o.
REQ-013 In IdleSt, when at least one agt_req_i bit is high, the block SHALL select an agent round-robin, with agent 0 highest priority after reset, and after a grant to agent i, priority SHALL start at agent (i+1) mod NumAgents.
REQ-014 The selected agent SHALL be locked: the selection SHALL NOT change while its request stays high and otp_gnt_i is low.
REQ-015 If a locked agent deasserts its request before being granted, the lock SHALL be released and arbitration SHALL rerun in the same cycle.
REQ-016 In IdleSt, otp_req_o and the cmd/size/wdata/addr fields SHALL be driven combinationally from the selected agent (zero latency); with no selection, otp_req_o SHALL be 0 and all fields 0.
REQ-017 When otp_gnt_i is high with otp_req_o high, agt_gnt_o[sel] SHALL be 1 in the same cycle, the owner index SHALL be registered, the priority pointer SHALL update, and the next state SHALL be WaitSt.
REQ-018 In WaitSt, otp_req_o SHALL be 0; on otp_rvalid_i, agt_rvalid_o[owner] SHALL be 1 in the same cycle, agt_rdata_o/agt_err_o SHALL equal otp_rdata_i/otp_err_i, and the next state SHALL be IdleSt; a new grant SHALL be possible no earlier than the following cycle.
REQ-019 agt_rdata_o and agt_err_o SHALL be 0 whenever otp_rvalid_i is not being forwarded.
REQ-020 otp_rvalid_i in IdleSt SHALL be treated as a protocol error: no agt_rvalid_o, fsm_err_o pulse, and transition to ErrorSt.
REQ-021 An asserted otp_gnt_i without otp_req_o SHALL be ignored.
REQ-022 Escalation SHALL override every state: the next state SHALL be ErrorSt and fsm_err_o SHALL be 1 that cycle, and any grant or rvalid in that same cycle SHALL be suppressed.
REQ-023 ErrorSt SHALL be terminal: otp_req_o=0, agt_gnt_o=0, agt_rvalid_o=0, idle_o=0, and late otp_rvalid_i SHALL be dropped.

Reset
REQ-024 While rst_ni is low, the state SHALL be IdleSt, the owner 0, the priority pointer 0, all outputs 0 except idle_o=1, and fsm_err_o=0.
REQ-025 A reset asserted mid-transaction SHALL abandon the outstanding response; an otp_rvalid_i arriving after reset release SHALL follow REQ-020.

Verification
REQ-026 The bench SHALL cover: agents 0 and 1 both request, gnt held low for 3 cycles -> otp_addr_o stays at agent 0's address; gnt -> agt_gnt_o=01; rvalid -> agt_rvalid_o=01.
REQ-027 The bench SHALL cover: both agents requesting continuously for 4 transactions -> grant order 0,1,0,1, with WaitSt entered each time.
REQ-028 The bench SHALL cover: agent 1 read at addr 0x2A, otp_rdata_i=0xDEADBEEF, otp_err_i=1 -> agt_rvalid_o=10, agt_rdata_o=0xDEADBEEF, agt_err_o=1, zero latency.
REQ-029 The bench SHALL cover: otp_rvalid_i pulsed in IdleSt -> fsm_err_o=1 for 1 cycle, ErrorSt, and subsequent requests never granted.
REQ-030 The bench SHALL cover: escalate_en_i=On during WaitSt with rvalid in the same cycle -> agt_rvalid_o=0, ErrorSt, and otp_req_o stays 0.
REQ-031 The bench SHALL cover: state register forced to an invalid encoding -> fsm_err_o pulse and ErrorSt on the next cycle.
